// File: rtl/csa_accum_arbiter.sv
// Two-requester shared multi-operand adder: carry-save accumulation, one final carry-propagate add.
// Optional CSA_ACCUM_OVF_EN adds res_ovf, flagging packets cut off at MAX_OPS without req_last.
module csa_accum_arbiter #(
  parameter int unsigned W       = 64,
  parameter int unsigned MAX_OPS = 16,
  localparam int unsigned CW     = $clog2(MAX_OPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0][W-1:0]   req_data,
  input  logic [1:0]          req_last,
  output logic [1:0]          req_ready,
  output logic                res_valid,
  output logic [W-1:0]        res_data,
  output logic                res_id,
  output logic [CW-1:0]       res_count,
`ifdef CSA_ACCUM_OVF_EN
  output logic                res_ovf,
`endif
  input  logic                res_ready
);

  typedef enum logic [1:0] {StIdle, StAccum, StResolve, StOut} state_e;

  state_e        state_q;
  logic          grant_q;
  logic          last_grant_q;
  logic [W-1:0]  psum_q;
  logic [W-1:0]  carry_q;
  logic [CW-1:0] count_q;
`ifdef CSA_ACCUM_OVF_EN
  logic          forced_q;
`endif

  logic [W-1:0]  beat_data;
  logic [W-1:0]  beat_maj;
  logic [CW-1:0] count_inc;
  logic          beat_acc;
  logic          beat_forced;
  logic          beat_term;
  logic          next_grant;

  always_comb begin
    beat_data   = req_data[grant_q];
    beat_maj    = (beat_data & psum_q) | (beat_data & carry_q) | (psum_q & carry_q);
    count_inc   = count_q + 1'b1;
    beat_acc    = (state_q == StAccum) && req_valid[grant_q];
    beat_forced = (count_inc == CW'(MAX_OPS));
    beat_term   = req_last[grant_q] || beat_forced;
    // On a tie the requester that did not win last time gets the adder.
    next_grant  = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  end

  // Ready is a pure decode of registered state, so it cannot glitch.
  assign req_ready = (state_q != StAccum) ? 2'b00 : (grant_q ? 2'b10 : 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      psum_q       <= '0;
      carry_q      <= '0;
      count_q      <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_id       <= 1'b0;
      res_count    <= '0;
`ifdef CSA_ACCUM_OVF_EN
      forced_q     <= 1'b0;
      res_ovf      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            grant_q <= next_grant;
            psum_q  <= '0;
            carry_q <= '0;
            count_q <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (beat_acc) begin
            psum_q  <= beat_data ^ psum_q ^ carry_q;
            carry_q <= beat_maj << 1;  // bit W-1 carry is dropped: arithmetic is mod 2^W
            count_q <= count_inc;
`ifdef CSA_ACCUM_OVF_EN
            forced_q <= beat_forced && !req_last[grant_q];
`endif
            if (beat_term) state_q <= StResolve;
          end
        end
        StResolve: begin
          res_data  <= psum_q + carry_q;
          res_id    <= grant_q;
          res_count <= count_q;
`ifdef CSA_ACCUM_OVF_EN
          res_ovf   <= forced_q;
`endif
          res_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (res_ready) begin
            res_valid    <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/csa_accum_arbiter.md
Name: csa_accum_arbiter

Overview:
- Shared multi-operand 64-bit adder for the hash core. It arbitrates between two requesters, each streaming a packet of operands (for example, T1 terms or message-schedule W terms).
- Operands are accumulated one beat per cycle in carry-save form, as a 3:2 compression of {operand, psum, carry}.
- On packet end, a single carry-propagate add resolves the result, which is returned with the requester id.
- All arithmetic is mod 2^W.

Parameters:
W, 64, operand/result width in bits
MAX_OPS, 16, maximum operands per packet; beat number MAX_OPS is forced to terminate the packet

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  2  per-requester operand valid
req_data  input  2xW  per-requester operand; requester r uses slice r
req_last  input  2  per-requester last operand of packet
req_ready  output  2  per-requester operand accepted this cycle (when valid)
res_valid  output  1  result valid
res_data  output  W  sum of packet operands mod 2^W
res_id  output  1  requester that owns the result
res_count  output  $clog2(MAX_OPS+1)  number of operands summed
res_ready  input  1  result consumer ready

Behaviour:
- Reset: clk rising edge with rst=1.
  - State goes to IDLE. psum, carry and count are cleared to 0.
  - res_valid=0, res_data=0, res_id=0, res_count=0, req_ready=0.
  - last_grant=1, so requester 0 wins the first tie.
  - rst overrides all other inputs in any state. An in-flight packet is discarded, with no partial result.
- FSM states: IDLE, ACCUM, RESOLVE, OUT.
- IDLE:
  - req_ready=0.
  - If any req_valid, register grant: the sole requester, or on a tie the requester != last_grant.
  - Clear psum, carry and count, then go to ACCUM.
  - Grant is not re-evaluated until the next IDLE.
- ACCUM:
  - req_ready[grant]=1; the other bit is 0.
  - On each accepted beat (valid&ready):
    - psum <= d^psum^carry
    - carry <= (maj(d,psum,carry) << 1) truncated to W bits
    - count <= count+1
  - Beat is terminal if req_last=1 or count+1==MAX_OPS. A terminal beat moves the FSM to RESOLVE.
  - If no beat is accepted, hold state and registers; there is no timeout.
- RESOLVE:
  - req_ready=0.
  - res_data <= psum+carry (mod 2^W); res_id <= grant; res_count <= count.
  - Go to OUT.
- OUT:
  - res_valid=1. res_data, res_id and res_count are held stable until res_valid&res_ready.
  - On handshake: res_valid <= 0, last_grant <= grant, go to IDLE.
  - res_ready is ignored in all other states.
- Latency:
  - Terminal beat accepted at cycle t gives res_valid=1 from cycle t+2.
  - Minimum packet-to-packet spacing is 1 IDLE cycle after the OUT handshake.
  - Grant-to-first-accept is 1 cycle (IDLE→ACCUM).
- Boundaries:
  - A 1-operand packet returns the operand unchanged.
  - A non-granted requester sees req_ready=0 and must hold its data; the block never drops beats.
  - After forced termination at MAX_OPS, subsequent beats from the same requester form a new packet, competing in IDLE normally.
  - res_data always equals the exact integer sum mod 2^W. Carry out of bit W-1 is discarded every cycle, which is consistent mod 2^W.

Optional Feature:
- Macro: CSA_ACCUM_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit), registered in RESOLVE.
  - res_ovf=1 iff the packet was terminated by the MAX_OPS limit with req_last=0 on that beat.
  - Valid and held with res_valid; reset value 0.
- Undefined:
  - The port is absent.
  - Forced termination behaviour is identical, just unflagged.

Test Plan:
1. Req0 sends 1, 2, 3 (last on 3) → res_data=6, res_id=0, res_count=3; res_valid rises 2 cycles after the beat-3 accept.
2. Req1 sends 0xFFFF_FFFF_FFFF_FFFF, 2 (last) → res_data=1, res_id=1, res_count=2 (mod-2^64 wrap).
3. Both requesters valid continuously from reset with 2-beat packets → grants go 0,1,0,1; the non-granted req_ready stays 0 throughout each packet.
4. res_ready held 0 for 5 cycles in OUT → res_valid=1 and res_data/res_id/res_count stable; req_ready=00; release gives a 1-cycle handshake, then IDLE.
5. MAX_OPS=16, req0 sends 17 operands of value 1 with last only on beat 17:
   - First result: res_data=16, res_count=16, res_ovf=1 if CSA_ACCUM_OVF_EN.
   - Second result: res_data=1, res_count=1, res_ovf=0.
6. rst pulsed for 1 cycle after 2 accepted beats (5, 7) of a packet:
   - Next cycle: res_valid=0, req_ready=00.
   - A new packet 4 (last) yields res_data=4, res_count=1.
